// File: rtl/reg_file_burst_if.sv
// Bus between the SPI frame decoder (master) and the burst register bank (slave).
// Optional write-lock line is present when REG_FILE_WR_LOCK_EN is defined.
interface reg_file_burst_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDRESS_SIZE = 8
);
  // Strobe semantics: i_wr_en/i_rd_en each request one register access in the cycle they are
  // high; there is no ready, the bank always accepts. o_rd_valid/o_err pulse for exactly one
  // cycle after the access they describe, and o_data holds between reads.
  logic [ADDRESS_SIZE-1:0] i_address;
  logic                    i_addr_load;
  logic [DATA_WIDTH-1:0]   i_data;
  logic                    i_wr_en;
`ifdef REG_FILE_WR_LOCK_EN
  logic                    i_wr_lock;
`endif
  logic                    i_rd_en;
  logic [DATA_WIDTH-1:0]   o_data;
  logic                    o_rd_valid;
  logic                    o_err;
  logic [ADDRESS_SIZE-1:0] o_ptr;

  modport master (
    output i_address, i_addr_load, i_data, i_wr_en,
`ifdef REG_FILE_WR_LOCK_EN
    output i_wr_lock,
`endif
    output i_rd_en,
    input  o_data, o_rd_valid, o_err, o_ptr
  );

  modport slave (
    input  i_address, i_addr_load, i_data, i_wr_en,
`ifdef REG_FILE_WR_LOCK_EN
    input  i_wr_lock,
`endif
    input  i_rd_en,
    output o_data, o_rd_valid, o_err, o_ptr
  );
endinterface

// File: rtl/reg_file_burst.sv
// Register bank with auto-incrementing burst pointer, registered read and out-of-range detection.
// Define REG_FILE_WR_LOCK_EN to add the i_wr_lock write-protect input.
module reg_file_burst #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 64,
  parameter int ADDRESS_SIZE = 8
) (
  input logic           i_clk,
  input logic           i_rst_n,
  reg_file_burst_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDRESS_SIZE and A+1 past the top are both representable.
  localparam logic [ADDRESS_SIZE:0] DEPTH_EXT = (ADDRESS_SIZE+1)'(DEPTH);
  localparam logic [ADDRESS_SIZE:0] ONE_EXT   = (ADDRESS_SIZE+1)'(1);

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    err_q, err_d;
  logic [ADDRESS_SIZE-1:0] ptr_q, ptr_d;

  logic                    access;
  logic [ADDRESS_SIZE-1:0] addr_a;
  logic [ADDRESS_SIZE:0]   addr_ext;
  logic [ADDRESS_SIZE:0]   inc_ext;
  logic                    legal;
  logic                    wr_lock;
  logic                    mem_we;
  logic [IDX_W-1:0]        idx;

`ifdef REG_FILE_WR_LOCK_EN
  assign wr_lock = bus.i_wr_lock;
`else
  assign wr_lock = 1'b0;
`endif

  always_comb begin
    access     = bus.i_wr_en | bus.i_rd_en;
    addr_a     = bus.i_addr_load ? bus.i_address : ptr_q;
    addr_ext   = {1'b0, addr_a};
    inc_ext    = addr_ext + ONE_EXT;
    legal      = addr_ext < DEPTH_EXT;
    idx        = addr_a[IDX_W-1:0];
    mem_we     = bus.i_wr_en & legal & ~wr_lock;

    // A+1 falling outside the bank covers both the normal wrap and wild-pointer recovery.
    ptr_d = ptr_q;
    if (access) begin
      ptr_d = (inc_ext < DEPTH_EXT) ? inc_ext[ADDRESS_SIZE-1:0] : '0;
    end else if (bus.i_addr_load) begin
      ptr_d = bus.i_address;
    end

    data_d = data_q;
    if (bus.i_rd_en) begin
      data_d = legal ? mem_q[idx] : '0;
    end
    rd_valid_d = bus.i_rd_en;
    err_d      = access & (~legal | (bus.i_wr_en & wr_lock));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      ptr_q      <= '0;
    end else begin
      // Read samples mem_q before this edge's write lands, giving read-before-write.
      if (mem_we) begin
        mem_q[idx] <= bus.i_data;
      end
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.o_data     = data_q;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_err      = err_q;
  assign bus.o_ptr      = ptr_q;
endmodule

// File: tb/tb_reg_file_burst.sv
// Directed table-driven bench for reg_file_burst, plus a hand-written wrapping burst sequence.
// Lock vectors are included when REG_FILE_WR_LOCK_EN is defined.
module tb_reg_file_burst;
  localparam int DW = 8;
  localparam int AS = 8;

  logic i_clk;
  logic i_rst_n;
  int   n_tests;
  int   n_fail;
  logic [DW-1:0] exp_q[$];

  reg_file_burst_if #(.DATA_WIDTH(DW), .ADDRESS_SIZE(AS)) bus ();

  reg_file_burst #(.DATA_WIDTH(DW), .DEPTH(64), .ADDRESS_SIZE(AS)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic          rst_n;
    logic          load;
    logic [AS-1:0] addr;
    logic          wr;
    logic          rd;
    logic          lock;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    logic          exp_err;
    logic [AS-1:0] exp_ptr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst_n, logic load, logic [AS-1:0] addr, logic wr, logic rd,
                              logic lock, logic [DW-1:0] data, logic [DW-1:0] exp_data,
                              logic exp_valid, logic exp_err, logic [AS-1:0] exp_ptr);
    vec_t v;
    v.rst_n = rst_n; v.load = load; v.addr = addr; v.wr = wr; v.rd = rd; v.lock = lock;
    v.data = data; v.exp_data = exp_data; v.exp_valid = exp_valid; v.exp_err = exp_err;
    v.exp_ptr = exp_ptr;
    return v;
  endfunction

  task automatic check(input string name, input int id, input logic [15:0] got,
                       input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step%0d got %h expected %h", name, id, got, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic load, input logic [AS-1:0] addr,
                       input logic wr, input logic rd, input logic lock, input logic [DW-1:0] data);
    i_rst_n         = rst_n;
    bus.i_addr_load = load;
    bus.i_address   = addr;
    bus.i_wr_en     = wr;
    bus.i_rd_en     = rd;
    bus.i_data      = data;
`ifdef REG_FILE_WR_LOCK_EN
    bus.i_wr_lock   = lock;
`else
    if (lock) $display("note: lock vector applied without lock port");
`endif
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_outputs(input int id, input logic [DW-1:0] d, input logic v,
                               input logic e, input logic [AS-1:0] p);
    check("o_data",     id, 16'(bus.o_data),     16'(d));
    check("o_rd_valid", id, 16'(bus.o_rd_valid), 16'(v));
    check("o_err",      id, 16'(bus.o_err),      16'(e));
    check("o_ptr",      id, 16'(bus.o_ptr),      16'(p));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    i_rst_n = 1'b0;
    bus.i_addr_load = 1'b0; bus.i_address = '0; bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0; bus.i_data = '0;
`ifdef REG_FILE_WR_LOCK_EN
    bus.i_wr_lock = 1'b0;
`endif

    //                rst ld addr   wr rd lk data   exp_d  v  e  ptr
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00)); // reset
    vecs.push_back(mk(1, 1, 8'h02, 1, 0, 0, 8'h15, 8'h00, 0, 0, 8'h03)); // write @2
    vecs.push_back(mk(1, 1, 8'h02, 0, 1, 0, 8'h00, 8'h15, 1, 0, 8'h03)); // read @2
    vecs.push_back(mk(1, 1, 8'h3E, 1, 0, 0, 8'hA1, 8'h15, 0, 0, 8'h3F)); // burst start
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'hA2, 8'h15, 0, 0, 8'h00)); // wrap
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'hA3, 8'h15, 0, 0, 8'h01));
    vecs.push_back(mk(1, 1, 8'h3E, 0, 1, 0, 8'h00, 8'hA1, 1, 0, 8'h3F));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 8'hA2, 1, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 8'hA3, 1, 0, 8'h01));
    vecs.push_back(mk(1, 1, 8'hA6, 1, 0, 0, 8'h99, 8'hA3, 0, 1, 8'h00)); // illegal write
    vecs.push_back(mk(1, 1, 8'hA6, 0, 1, 0, 8'h00, 8'h00, 1, 1, 8'h00)); // illegal read
    vecs.push_back(mk(1, 1, 8'h3F, 0, 1, 0, 8'h00, 8'hA2, 1, 0, 8'h00));
    vecs.push_back(mk(1, 1, 8'h26, 0, 1, 0, 8'h00, 8'h00, 1, 0, 8'h27)); // alias untouched
    vecs.push_back(mk(1, 1, 8'hA6, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'hA6)); // load wild ptr
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 8'h00, 1, 1, 8'h00)); // wild ptr recovers
    vecs.push_back(mk(1, 1, 8'h05, 1, 0, 0, 8'h11, 8'h00, 0, 0, 8'h06));
    vecs.push_back(mk(1, 1, 8'h05, 1, 1, 0, 8'hFF, 8'h11, 1, 0, 8'h06)); // read-before-write
    vecs.push_back(mk(1, 1, 8'h05, 0, 1, 0, 8'h00, 8'hFF, 1, 0, 8'h06));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFF, 0, 0, 8'h06)); // idle holds
    vecs.push_back(mk(1, 1, 8'h0A, 1, 0, 0, 8'h12, 8'hFF, 0, 0, 8'h0B));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'h34, 8'hFF, 0, 0, 8'h0C));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h56, 8'h00, 0, 0, 8'h00)); // mid-burst reset
    vecs.push_back(mk(1, 1, 8'h0A, 0, 1, 0, 8'h00, 8'h00, 1, 0, 8'h0B));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 8'h00, 1, 0, 8'h0C));
`ifdef REG_FILE_WR_LOCK_EN
    vecs.push_back(mk(1, 1, 8'h03, 1, 0, 1, 8'h55, 8'h00, 0, 1, 8'h04)); // locked write
    vecs.push_back(mk(1, 1, 8'h03, 0, 1, 1, 8'h00, 8'h00, 1, 0, 8'h04)); // read under lock
    vecs.push_back(mk(1, 1, 8'h03, 1, 0, 0, 8'h55, 8'h00, 0, 0, 8'h04));
    vecs.push_back(mk(1, 1, 8'h03, 0, 1, 0, 8'h00, 8'h55, 1, 0, 8'h04));
`endif

    @(negedge i_clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].load, vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].lock,
            vecs[i].data);
      check_outputs(i, vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_err, vecs[i].exp_ptr);
    end

    // Six-byte burst from @61 wraps through 63 -> 0; read back as a burst.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i == 0), 8'd61, 1'b1, 1'b0, 1'b0, DW'(8'hC0 + i));
      exp_q.push_back(DW'(8'hC0 + i));
    end
    check("burst_wr_ptr", 100, 16'(bus.o_ptr), 16'h0003);
    for (int i = 0; i < 6; i++) begin
      logic [DW-1:0] exp_d;
      drive(1'b1, (i == 0), 8'd61, 1'b0, 1'b1, 1'b0, '0);
      exp_d = exp_q.pop_front();
      check("burst_rd_data",  200 + i, 16'(bus.o_data),     16'(exp_d));
      check("burst_rd_valid", 200 + i, 16'(bus.o_rd_valid), 16'h0001);
    end
    check("burst_rd_ptr", 300, 16'(bus.o_ptr), 16'h0003);
    drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, '0);
    check("valid_pulse_end", 301, 16'(bus.o_rd_valid), 16'h0000);
    check("data_hold",       301, 16'(bus.o_data),     16'h00C5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
